mem_arbiter: RTL

Shares one single-ported unified memory between the CPU instruction-fetch port and data port of `cpu_top`. It replaces the split instruction/data memory models used in the current benches. The block grants one requester at a time and forwards its access to the memory over a req/ready handshake with arbitrary wait states. It returns read data with a one-cycle acknowledge and aborts accesses the memory never completes.

---
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D port arbiter onto one single-ported memory; define MEM_ARB_RR_EN for round-robin ties
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  output logic                i_err,
  input  logic                d_req,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wen,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                d_err,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wen,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);
  localparam int         BE_W     = DATA_W / 8;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]     mem_wen_q, mem_wen_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                i_ack_q, i_ack_d;
  logic                i_err_q, i_err_d;
  logic                d_ack_q, d_ack_d;
  logic                d_err_q, d_err_d;
  logic                pick_d;
  logic                done;

`ifdef MEM_ARB_RR_EN
  logic                last_d_q, last_d_d;

  // On a tie, grant the port that was not granted last
  always_comb begin
    pick_d = d_req;
    if (d_req && i_req) begin
      pick_d = !last_d_q;
    end
  end
`else
  // Fixed priority: a pending D request always wins
  always_comb begin
    pick_d = d_req;
  end
`endif

  // Next state and next value of every registered output
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wen_d   = mem_wen_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ack_d     = 1'b0;
    i_err_d     = 1'b0;
    d_ack_d     = 1'b0;
    d_err_d     = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_d_d    = last_d_q;
`endif
    done        = mem_ready || (cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        if (d_req || i_req) begin
          mem_req_d = 1'b1;
          cnt_d     = 8'd0;
          if (pick_d) begin
            state_d     = BUSY_D;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_wen_d   = d_wen;
          end else begin
            state_d     = BUSY_I;
            mem_addr_d  = i_addr;
            mem_wdata_d = '0;
            mem_wen_d   = '0;
          end
`ifdef MEM_ARB_RR_EN
          last_d_d = pick_d;
`endif
        end
      end
      BUSY_I, BUSY_D: begin
        if (done) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          mem_wen_d = '0;
          if (state_q == BUSY_I) begin
            i_ack_d   = 1'b1;
            i_err_d   = !mem_ready;
            i_rdata_d = mem_ready ? mem_rdata : '0;
          end else begin
            d_ack_d = 1'b1;
            d_err_d = !mem_ready;
            if (!mem_ready) begin
              d_rdata_d = '0;
            end else if (mem_wen_q == '0) begin
              d_rdata_d = mem_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wen_q   <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ack_q     <= 1'b0;
      i_err_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wen_q   <= mem_wen_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ack_q     <= i_ack_d;
      i_err_q     <= i_err_d;
      d_ack_q     <= d_ack_d;
      d_err_q     <= d_err_d;
`ifdef MEM_ARB_RR_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wen   = mem_wen_q;
  assign i_rdata   = i_rdata_q;
  assign i_ack     = i_ack_q;
  assign i_err     = i_err_q;
  assign d_rdata   = d_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;

endmodule
